// File: rtl/full_adder_pkg.sv
// Shared constants for the full adder slice.
// Pure definitions; no logic, latency or flow control.
package full_adder_pkg;
    localparam int FA_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_bit.sv
// 1-bit full adder cell: s = a^b^cin, cout = majority(a,b,cin).
// Purely combinational, zero latency, no backpressure.
module full_adder_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH full_adder_bit cells: combinational SUM/COUT (0 cycles)
// plus a registered copy SUM_Q/COUT_Q (1 cycle); no handshake, never stalls.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic [WIDTH-1:0] SUM_Q,
    output logic             COUT_Q
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum_q;
    logic             r_cout_q;

    assign w_carry[0] = CIN;

    // Carry ripples LSB to MSB; the final carry is the (WIDTH+1)th result bit.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        full_adder_bit u_bit (
            .i_a    (A[g]),
            .i_b    (B[g]),
            .i_cin  (w_carry[g]),
            .o_s    (w_sum[g]),
            .o_cout (w_carry[g+1])
        );
    end

    assign SUM  = w_sum;
    assign COUT = w_carry[WIDTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sum_q  <= '0;
            r_cout_q <= 1'b0;
        end else begin
            r_sum_q  <= w_sum;
            r_cout_q <= w_carry[WIDTH];
        end
    end

    assign SUM_Q  = r_sum_q;
    assign COUT_Q = r_cout_q;
endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic [0:0] s1, sq1;
    logic       co1, coq1;

    logic [3:0] a4 = '0, b4 = '0;
    logic       c4 = 1'b0;
    logic [3:0] s4, sq4;
    logic       co4, coq4;

    int errors = 0;
    int checks = 0;

    full_adder #(.WIDTH(1)) u_w1 (
        .CLK(clk), .RST(rst), .A(a1), .B(b1), .CIN(c1),
        .SUM(s1), .COUT(co1), .SUM_Q(sq1), .COUT_Q(coq1)
    );

    full_adder #(.WIDTH(4)) u_w4 (
        .CLK(clk), .RST(rst), .A(a4), .B(b4), .CIN(c4),
        .SUM(s4), .COUT(co4), .SUM_Q(sq4), .COUT_Q(coq4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_prev;
        logic [7:0] exp_now;
        logic [2:0] v;

        // Reset state
        #2;
        check("reset_q_w1", {6'b0, coq1, sq1}, 8'h00);
        check("reset_q_w4", {3'b0, coq4, sq4}, 8'h00);

        // WIDTH=1 exhaustive truth table, RST held high
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; c1 = v[0];
            #1;
            // {cout,sum} as a 2-bit value equals the population count of v
            check("truth_w1", {6'b0, co1, s1}, 8'(32'(v[2]) + 32'(v[1]) + 32'(v[0])));
            #9;
        end
        check("truth_sum_111", {7'b0, s1}, 8'h01);

        // Combinational outputs live under reset; registered ones stay 0 across edges
        a1 = 1; b1 = 1; c1 = 1;
        #1;
        check("rst_comb_111", {6'b0, co1, s1}, 8'h03);
        repeat (3) @(posedge clk);
        #1;
        check("rst_q_hold", {6'b0, coq1, sq1}, 8'h00);

        // Release reset: first capture only after the next rising edge
        @(negedge clk);
        rst = 0;
        a1 = 1; b1 = 0; c1 = 1;
        #1;
        check("q_before_edge", {6'b0, coq1, sq1}, 8'h00);
        @(posedge clk);
        #1;
        check("q_after_edge", {6'b0, coq1, sq1}, 8'h02);

        // Async reset between edges clears SUM_Q at once
        a1 = 1; b1 = 0; c1 = 0;
        @(posedge clk);
        #1;
        check("q_sum_one", {6'b0, coq1, sq1}, 8'h01);
        #2;
        rst = 1;
        #1;
        check("async_clear", {6'b0, coq1, sq1}, 8'h00);
        check("comb_during_rst", {6'b0, co1, s1}, 8'h01);
        @(negedge clk);
        rst = 0;

        // WIDTH=4 directed vectors
        a4 = 4'd15; b4 = 4'd1; c4 = 0;
        #1;
        check("w4_15_1_0", {3'b0, co4, s4}, 8'h10);
        a4 = 4'd7; b4 = 4'd8; c4 = 1;
        #1;
        check("w4_7_8_1", {3'b0, co4, s4}, 8'h10);
        a4 = 4'd5; b4 = 4'd2; c4 = 0;
        #1;
        check("w4_5_2_0", {3'b0, co4, s4}, 8'h07);

        // WIDTH=4 random vectors with one-cycle registered check
        @(negedge clk);
        exp_prev = 8'h07;
        for (int n = 0; n < 1000; n++) begin
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            c4 = 1'($urandom_range(0, 1));
            exp_now = 8'(32'(a4) + 32'(b4) + 32'(c4));
            #1;
            check("w4_rand_comb", {3'b0, co4, s4}, exp_now);
            @(negedge clk);
            check("w4_rand_q", {3'b0, coq4, sq4}, exp_now);
            exp_prev = exp_now;
        end
        @(posedge clk);
        #1;
        check("w4_final_q", {3'b0, coq4, sq4}, exp_prev);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
